// File: rtl/matrix_loader_pkg.sv
// matrix_loader_pkg
// Shared constants for the operand loader: default matrix geometry and
// element width (also consumed by vga_rtl_top), loader state encoding,
// and a small sizing helper.
package matrix_loader_pkg;

  localparam int DEFAULT_MATRIX_N = 3;
  localparam int DEFAULT_MATRIX_M = 3;
  localparam int DEFAULT_WIDTH    = 16;

  // Loader state enumeration, binary encoded.
  localparam int         STATE_W         = 2;
  localparam logic [1:0] ST_LOAD_A       = 2'd0;
  localparam logic [1:0] ST_LOAD_B       = 2'd1;
  localparam logic [1:0] ST_PRESENT      = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  // Width of a counter that must hold 0..k-1; never narrower than one bit.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// matrix_loader_if
// Bundles the host word stream, the abort strobe and the operand hand-off
// to the compute/display core.
//   master : host/core side  (drives in_data, in_valid, clear, compute_done)
//   slave  : loader side     (drives in_ready, matrix_a, matrix_b,
//                             read_ready, busy)
interface matrix_loader_if
  import matrix_loader_pkg::*;
#(
  parameter int MATRIX_N = DEFAULT_MATRIX_N,
  parameter int MATRIX_M = DEFAULT_MATRIX_M,
  parameter int WIDTH    = DEFAULT_WIDTH
);

  localparam int MAT_W = MATRIX_N * MATRIX_M * WIDTH;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [MAT_W-1:0] matrix_a;
  logic [MAT_W-1:0] matrix_b;
  logic             read_ready;
  logic             compute_done;
  logic             busy;

  modport master (
    output in_data, in_valid, clear, compute_done,
    input  in_ready, matrix_a, matrix_b, read_ready, busy
  );

  modport slave (
    input  in_data, in_valid, clear, compute_done,
    output in_ready, matrix_a, matrix_b, read_ready, busy
  );

endinterface

// File: rtl/matrix_loader.sv
// matrix_loader
// Collects 2*K words (K = MATRIX_N*MATRIX_M) from a valid/ready stream into
// two packed row-major operand matrices, presents them to the core until it
// signals completion, then waits for that signal to drop before reloading.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - matrix_loader_if.slave (stream in, operands out, handshakes)
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int MATRIX_N = DEFAULT_MATRIX_N,
  parameter int MATRIX_M = DEFAULT_MATRIX_M,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             reset,
  matrix_loader_if.slave  bus
);

  localparam int K      = MATRIX_N * MATRIX_M;
  localparam int MAT_W  = K * WIDTH;
  localparam int CNT_W  = cnt_width(K);
  localparam int IDX_W  = cnt_width(MAT_W);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAT_W-1:0]   mat_a_q, mat_a_d;
  logic [MAT_W-1:0]   mat_b_q, mat_b_d;

  logic               loading;
  logic               accept;
  logic               last_word;
  logic [IDX_W-1:0]   wr_lsb;

  assign loading   = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  // in_ready is gated by reset directly so it is low for the whole reset
  // window, not just after the first edge.
  assign bus.in_ready = loading && !reset;
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_word = (cnt_q == CNT_W'(K - 1));
  // Bit offset of the element addressed by the counter (row-major, LSB first).
  assign wr_lsb    = IDX_W'(cnt_q) * IDX_W'(WIDTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    if (bus.clear) begin
      // Abort wins over any coincident accept: the word is dropped.
      state_d = ST_LOAD_A;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (accept) begin
            mat_a_d[wr_lsb +: WIDTH] = bus.in_data;
            if (last_word) begin
              cnt_d   = '0;
              state_d = ST_LOAD_B;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (accept) begin
            mat_b_d[wr_lsb +: WIDTH] = bus.in_data;
            if (last_word) begin
              cnt_d   = '0;
              state_d = ST_PRESENT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PRESENT: begin
          if (bus.compute_done) state_d = ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          // Wait for the level to fall so one long completion is one release.
          if (!bus.compute_done) state_d = ST_LOAD_A;
        end
        default: state_d = ST_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD_A;
      cnt_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
    end
  end

  assign bus.matrix_a   = mat_a_q;
  assign bus.matrix_b   = mat_b_q;
  assign bus.read_ready = (state_q == ST_PRESENT);
  assign bus.busy       = !((state_q == ST_LOAD_A) && (cnt_q == '0));

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter MATRIX_N, default 3, row count of each operand matrix.
REQ-002 Parameter MATRIX_M, default 3, column count of each operand matrix.
REQ-003 Parameter WIDTH, default 16, bit width of one matrix element.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port in_data  input  WIDTH  element word from the host stream.
REQ-007 Port in_valid  input  1  in_data holds a valid word.
REQ-008 Port in_ready  output  1  loader accepts a word this cycle.
REQ-009 Port clear  input  1  synchronous abort; discard the partial load and restart.
REQ-010 Port matrix_a  output  MATRIX_N*MATRIX_M*WIDTH  packed operand A.
REQ-011 Port matrix_b  output  MATRIX_N*MATRIX_M*WIDTH  packed operand B.
REQ-012 Port read_ready  output  1  operands are complete and stable for the compute/display core.
REQ-013 Port compute_done  input  1  core has consumed the operands; level or pulse.
REQ-014 Port busy  output  1  high in every state except LOAD_A with a zero count.

Function
REQ-015 Transfer: a word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-016 Order: the first K=MATRIX_N*MATRIX_M accepted words SHALL fill A and the next K SHALL fill B, both in row-major order.
REQ-017 Packing: element (i,j) SHALL occupy bits [(i*MATRIX_M+j)*WIDTH +: WIDTH], so element (0,0) sits at the LSBs.
REQ-018 States: LOAD_A, LOAD_B, PRESENT, WAIT_RELEASE; encoding is binary.
REQ-019 LOAD_A: in_ready=1; the word counter increments on each accept; the K-th accept moves to LOAD_B and clears the counter.
REQ-020 LOAD_B: same as LOAD_A; the K-th accept moves to PRESENT.
REQ-021 Timing: read_ready SHALL be 1 in the cycle immediately after the edge that accepts the final B word.
REQ-022 PRESENT: read_ready=1, in_ready=0, and matrix_a and matrix_b held constant.
REQ-023 compute_done=1 sampled in PRESENT SHALL move to WAIT_RELEASE with read_ready=0 the next cycle.
REQ-024 WAIT_RELEASE: in_ready=0; move to LOAD_A once compute_done=0, so a held level is not double-counted.
REQ-025 compute_done SHALL be ignored in LOAD_A and LOAD_B.
REQ-026 Matrix contents: matrix_a and matrix_b SHALL keep their previous values until overwritten element by element; only read_ready qualifies them.
REQ-027 clear=1 SHALL force LOAD_A and zero the counter on the next edge, in any state, including PRESENT (read_ready drops).
REQ-028 When clear=1 coincides with an accept, the word SHALL be discarded.
REQ-029 Counter width SHALL be clog2(K); it never exceeds K-1.

Reset
REQ-030 On reset=1, the block SHALL immediately enter LOAD_A with counter=0, matrix_a=0, matrix_b=0, read_ready=0 and busy=0.
REQ-031 While reset=1, in_ready SHALL be 0.
REQ-032 After reset releases, in_ready SHALL be 1 from the first clock edge.
REQ-033 Reset mid-load or mid-PRESENT SHALL discard all progress.

Structure
REQ-034 The shared package SHALL hold the state enumeration and the default MATRIX_N, MATRIX_M and WIDTH constants used by vga_rtl_top.
REQ-035 No sub-module is needed; the element write SHALL use an indexed part-select driven by the counter.

Verification
REQ-036 Sequential load: reset, then stream words 1..18 with in_valid always 1 -> matrix_a element (0,0)=1 and (2,2)=9, matrix_b (0,0)=10 and (2,2)=18; read_ready rises exactly 1 cycle after the 18th accept.
REQ-037 Back-pressure: in_valid stays 1 during PRESENT -> in_ready=0 and no matrix bit changes over 20 cycles.
REQ-038 Held compute_done: compute_done held at 1 for 5 cycles -> read_ready falls after 1 cycle, in_ready stays 0 until compute_done=0, then the next load starts at element A(0,0).
REQ-039 Gapped stream: in_valid toggles randomly with 50% density -> same final matrices as REQ-036, and read_ready is asserted only once.
REQ-040 Clear mid-load: clear=1 after 12 words, then 18 fresh words 100..117 -> matrix_a (0,0)=100 and matrix_b (2,2)=117.
REQ-041 Async reset in PRESENT: assert reset between clock edges -> read_ready=0 and both matrices zero without waiting for a clock edge.
